// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED helpers: parity-width derivation and data-bit placement.
// Used by both the decoder and the future encoder so the code layout lives in one place.
package hamming_pkg;

    // Smallest r with 2**r >= data_w + r + 1. Scanning downwards leaves the minimum in r.
    function automatic int par_w(input int data_w);
        int r;
        r = 0;
        for (int i = 30; i >= 1; i--) begin
            if ((longint'(1) << i) >= longint'(data_w + i + 1)) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Hamming position of data bit i: the i-th non-power-of-two position, counting from 1.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int k = 1; k <= i + 33; k++) begin
            if (!is_pow2(k)) begin
                if (cnt == i) begin
                    pos = k;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received codeword (bit 0 = overall parity).
// Shared between the decoder's first stage and the encoder's self-check path.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  syn_o,
    output logic              par_o
);

    // XOR of the positions of all set bits; zero for a valid Hamming word.
    always_comb begin
        syn_o = '0;
        for (int k = 1; k < CODE_W; k++) begin
            if (code_i[k]) begin
                syn_o = syn_o ^ PAR_W'(k);
            end
        end
    end

    assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder (syndrome register, then correct/classify register); 2-cycle latency, one word/cycle.
// Valid/ready on both sides: outputs hold while out_ready is low, input stalls only when both stages are full.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int N      = DATA_W + PAR_W,
    localparam int CODE_W = N + 1,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic [POS_W-1:0]  err_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic [PAR_W-1:0]  syn;
    logic              par;

    logic              v1_q, v1_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [PAR_W-1:0]  syn_q, syn_d;
    logic              par_q, par_d;

    logic              v2_q, v2_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              corr_q, corr_d;
    logic              uncorr_q, uncorr_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              ld1, ld2, out_xfer;
    logic [CODE_W-1:0] fixed;
    logic [DATA_W-1:0] data_fix;
    logic              cls_corr, cls_uncorr;
    logic [POS_W-1:0]  cls_pos;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .code_i (code_in),
        .syn_o  (syn),
        .par_o  (par)
    );

    assign ld2      = !v2_q || out_ready;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1 && !rst;
    assign out_xfer = v2_q && out_ready;

    // A nonzero syndrome is only a real single-bit position when the overall parity also failed.
    always_comb begin
        cls_corr   = 1'b0;
        cls_uncorr = 1'b0;
        cls_pos    = '0;
        fixed      = code_q;
        if (syn_q == '0) begin
            cls_corr = par_q;
        end else if (par_q && (int'(syn_q) <= N)) begin
            cls_corr = 1'b1;
            cls_pos  = POS_W'(syn_q);
            fixed    = code_q ^ (CODE_W'(1) << syn_q);
        end else begin
            cls_uncorr = 1'b1;
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_ext
        localparam int DP = data_pos(i);
        assign data_fix[i] = fixed[DP];
    end

    always_comb begin
        v1_d         = v1_q;
        code_d       = code_q;
        syn_d        = syn_q;
        par_d        = par_q;
        v2_d         = v2_q;
        data_d       = data_q;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        pos_d        = pos_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                code_d = code_in;
                syn_d  = syn;
                par_d  = par;
            end
        end

        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data_d   = data_fix;
                corr_d   = cls_corr;
                uncorr_d = cls_uncorr;
                pos_d    = cls_pos;
            end
        end

        // Clear takes priority over a same-cycle increment.
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_xfer) begin
            if (corr_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            code_q       <= '0;
            syn_q        <= '0;
            par_q        <= 1'b0;
            v2_q         <= 1'b0;
            data_q       <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            pos_q        <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            v1_q         <= v1_d;
            code_q       <= code_d;
            syn_q        <= syn_d;
            par_q        <= par_d;
            v2_q         <= v2_d;
            data_q       <= data_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            pos_q        <= pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = v2_q;
    assign data_out   = data_q;
    assign err_corr   = corr_q;
    assign err_uncorr = uncorr_q;
    assign err_pos    = pos_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule
